// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - round-robin writeback arbiter with register busy scoreboard
module regwrite_arbiter (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        A_Valid,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  output logic        A_Ready,
  input  logic        B_Valid,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  output logic        B_Ready,
  input  logic        Issue_Valid,
  input  logic [4:0]  Issue_Reg,
  input  logic [4:0]  Query_rs,
  input  logic [4:0]  Query_rt,
  output logic        Rs_Busy,
  output logic        Rt_Busy,
  output logic [31:0] Busy_Vector,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_Data
);

  // r_prio_b high means B wins the next contended cycle
  logic        r_prio_b;
  logic [31:0] r_busy;
  logic        r_regwrite;
  logic [4:0]  r_write_register;
  logic [31:0] r_write_data;

  logic        w_contend;
  logic        w_a_grant;
  logic        w_b_grant;
  logic        w_transfer;
  logic [4:0]  w_win_reg;
  logic [31:0] w_win_data;
  logic [31:0] w_busy_next;

  // Grants depend only on the two valids and the priority pointer
  always_comb begin
    w_contend  = A_Valid & B_Valid;
    w_a_grant  = A_Valid & (~B_Valid | ~r_prio_b);
    w_b_grant  = B_Valid & (~A_Valid | r_prio_b);
    w_transfer = w_a_grant | w_b_grant;
    w_win_reg  = w_b_grant ? B_Reg  : A_Reg;
    w_win_data = w_b_grant ? B_Data : A_Data;
  end

  // Scoreboard next state: clear the landing write first so a same-edge reissue keeps the bit set
  always_comb begin
    w_busy_next = r_busy;
    if (r_regwrite) begin
      w_busy_next[r_write_register] = 1'b0;
    end
    if (Issue_Valid && (Issue_Reg != 5'd0)) begin
      w_busy_next[Issue_Reg] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Priority pointer hands the next contended cycle to the loser of this one
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prio_b <= 1'b1;
    end else if (w_contend) begin
      r_prio_b <= ~r_prio_b;
    end
  end

  // Write stage: capture the winner; register 0 completes the handshake without a write enable
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_regwrite       <= 1'b0;
      r_write_register <= 5'd0;
      r_write_data     <= 32'd0;
    end else if (w_transfer) begin
      r_regwrite       <= (w_win_reg != 5'd0);
      r_write_register <= w_win_reg;
      r_write_data     <= w_win_data;
    end else begin
      r_regwrite       <= 1'b0;
    end
  end

  // Busy scoreboard register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign A_Ready        = w_a_grant;
  assign B_Ready        = w_b_grant;
  assign Rs_Busy        = r_busy[Query_rs];
  assign Rt_Busy        = r_busy[Query_rt];
  assign Busy_Vector    = r_busy;
  assign RegWrite       = r_regwrite;
  assign Write_register = r_write_register;
  assign Write_Data     = r_write_data;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - scoreboard bench for regwrite_arbiter
module tb_regwrite_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        A_Valid, B_Valid, Issue_Valid;
  logic [4:0]  A_Reg, B_Reg, Issue_Reg, Query_rs, Query_rt;
  logic [31:0] A_Data, B_Data;
  logic        A_Ready, B_Ready, Rs_Busy, Rt_Busy, RegWrite;
  logic [31:0] Busy_Vector, Write_Data;
  logic [4:0]  Write_register;

  regwrite_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Reg(B_Reg), .B_Data(B_Data), .B_Ready(B_Ready),
    .Issue_Valid(Issue_Valid), .Issue_Reg(Issue_Reg),
    .Query_rs(Query_rs), .Query_rt(Query_rt),
    .Rs_Busy(Rs_Busy), .Rt_Busy(Rt_Busy), .Busy_Vector(Busy_Vector),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_Data(Write_Data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  // Reference model state: who is favoured on contention, which registers await writeback,
  // and which write lands on the coming edge
  int          m_favour;           // 0 = A, 1 = B
  bit          m_busy[32];
  bit          m_land_we;
  logic [4:0]  m_land_reg;
  logic [4:0]  m_last_reg;
  logic [31:0] m_last_data;
  logic        got_a, got_b;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_favour    = 1;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_land_we   = 1'b0;
    m_land_reg  = 5'd0;
    m_last_reg  = 5'd0;
    m_last_data = 32'd0;
  endtask

  // One cycle of stimulus; the model decides the winner and queues the expected write
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ir,
                       input logic [4:0] qs, input logic [4:0] qt);
    bit a_win, b_win;
    @(negedge CLK);
    #2;
    A_Valid = av; A_Reg = ar; A_Data = ad;
    B_Valid = bv; B_Reg = br; B_Data = bd;
    Issue_Valid = iv; Issue_Reg = ir;
    Query_rs = qs; Query_rt = qt;
    #1;
    if (av && bv) begin
      a_win = (m_favour == 0);
      b_win = !a_win;
      m_favour = a_win ? 1 : 0;
    end else begin
      a_win = av;
      b_win = bv;
    end
    got_a = A_Ready;
    got_b = B_Ready;
    check("a_ready", {31'd0, A_Ready}, {31'd0, a_win});
    check("b_ready", {31'd0, B_Ready}, {31'd0, b_win});
    if (m_land_we) m_busy[m_land_reg] = 1'b0;
    if (iv && ir != 5'd0) m_busy[ir] = 1'b1;
    m_land_we = 1'b0;
    if (a_win || b_win) begin
      exp_t e;
      e.due = cyc + 1;
      e.rg  = b_win ? br : ar;
      e.d   = b_win ? bd : ad;
      e.we  = (e.rg != 5'd0);
      exp_q.push_back(e);
      m_land_we  = e.we;
      m_land_reg = e.rg;
    end
  endtask

  task automatic idle(input logic [4:0] qs);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, qs, 5'd0);
  endtask

  // Monitor: retire the write due this cycle and compare the observable state
  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("regwrite", {31'd0, RegWrite}, {31'd0, e.we});
        m_last_reg  = e.rg;
        m_last_data = e.d;
      end else begin
        check("regwrite_idle", {31'd0, RegWrite}, 32'd0);
      end
      check("write_register", {27'd0, Write_register}, {27'd0, m_last_reg});
      check("write_data", Write_Data, m_last_data);
      check("busy_vector", Busy_Vector, model_vec());
      check("rs_busy", {31'd0, Rs_Busy}, {31'd0, m_busy[Query_rs]});
      check("rt_busy", {31'd0, Rt_Busy}, {31'd0, m_busy[Query_rt]});
    end
  end

  logic [3:0] order;

  initial begin
    RESET_N = 1'b0;
    A_Valid = 0; A_Reg = 0; A_Data = 0;
    B_Valid = 0; B_Reg = 0; B_Data = 0;
    Issue_Valid = 0; Issue_Reg = 0; Query_rs = 0; Query_rt = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    check("reset_wreg", {27'd0, Write_register}, 32'd0);
    check("reset_wdata", Write_Data, 32'd0);
    check("reset_busy", Busy_Vector, 32'd0);
    #2 RESET_N = 1'b1;
    mon_en = 1'b1;

    // Single requester
    drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("single_a_ready", {31'd0, got_a}, 32'd1);
    idle(5'd0);
    idle(5'd0);

    // Contention: B first after reset, then alternating
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd9, 32'hA000_0000 + i, 1'b1, 5'd10, 32'hB000_0000 + i, 1'b0, 5'd0, 5'd0, 5'd0);
      order[i] = got_a;
    end
    check("contention_order", {28'd0, order}, 32'b1010);
    idle(5'd0);

    // $zero write and issue
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    check("zero_b_ready", {31'd0, got_b}, 32'd1);
    idle(5'd0);
    idle(5'd0);

    // Scoreboard set and clear of r12
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
    idle(5'd12);
    drive(1'b1, 5'd12, 32'h0C0C0C0C, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd0);
    idle(5'd12);
    check("sb_busy_until_write", {31'd0, Rs_Busy}, 32'd1);
    idle(5'd12);
    check("sb_cleared", {31'd0, Rs_Busy}, 32'd0);

    // Reissue of r12 on the same edge its write lands
    drive(1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
    idle(5'd12);
    check("set_beats_clear", {31'd0, Rs_Busy}, 32'd1);

    // Reset in the middle of a write
    drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    @(posedge CLK);
    mon_en = 1'b0;
    #1 check("rst_mid_we_before", {31'd0, RegWrite}, 32'd1);
    #3 RESET_N = 1'b0;
    #1;
    check("rst_mid_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_mid_wdata", Write_Data, 32'd0);
    check("rst_mid_busy", Busy_Vector, 32'd0);
    A_Valid = 1'b1; B_Valid = 1'b1; Issue_Valid = 1'b0;
    #1;
    check("rst_prio_b", {30'd0, A_Ready, B_Ready}, 32'b01);
    A_Valid = 1'b0; B_Valid = 1'b0;
    model_reset();
    @(negedge CLK);
    #1 RESET_N = 1'b1;
    mon_en = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] ar, br, ir;
      ar = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      br = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ir = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      drive(1'($urandom_range(0, 1)), ar, $urandom,
            1'($urandom_range(0, 1)), br, $urandom,
            1'($urandom_range(0, 1)), ir,
            5'($urandom), 5'($urandom));
    end
    idle(5'd0);
    idle(5'd0);
    @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Shares the register file's single write port between two writeback requesters: ALU results (port A) and load returns (port B). Each requester uses a valid/ready handshake, and contention is resolved round-robin. The granted write is registered onto the Registers write port. The block also keeps a 32-entry busy scoreboard so the issue logic can stall on registers whose producer has not yet written back.

## Interface

Parameters
- none; widths are fixed by the ISA (5-bit register index, 32-bit data).

Ports
- CLK  input  1  single clock; all state updates on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- A_Valid  input  1  ALU writeback request.
- A_Reg  input  5  ALU destination register.
- A_Data  input  32  ALU result.
- A_Ready  output  1  A request accepted this cycle (combinational).
- B_Valid  input  1  load-return request.
- B_Reg  input  5  load destination register.
- B_Data  input  32  load data.
- B_Ready  output  1  B request accepted this cycle (combinational).
- Issue_Valid  input  1  an instruction with a destination register issues this cycle.
- Issue_Reg  input  5  that instruction's destination register.
- Query_rs, Query_rt  input  5 each  source registers of the instruction being decoded.
- Rs_Busy, Rt_Busy  output  1 each  combinational: busy[Query_rs], busy[Query_rt].
- Busy_Vector  output  32  current scoreboard.
- RegWrite  output  1  registered write enable to Registers.
- Write_register  output  5  registered write index.
- Write_Data  output  32  registered write data.

## Operation

- Handshake: a transfer occurs when Valid and Ready are both high in the same cycle. At most one of A_Ready and B_Ready is high in any cycle. Ready never depends on anything other than the two Valids and the priority pointer.
- Arbitration:
  - Only A valid: A wins.
  - Only B valid: B wins.
  - Both valid: the side named by the priority pointer `prio` wins.
- Priority pointer: `prio` resets to B. After a contended grant, `prio` moves to the loser. Uncontended grants leave `prio` unchanged.
- Write register stage: on the edge that completes a transfer, the winner's Reg and Data are captured into Write_register and Write_Data. RegWrite is set to 1 unless the winner's Reg is 0. With no transfer, RegWrite is 0 and Write_register and Write_Data hold their values.
- $zero: writes to register 0 still complete the handshake, but RegWrite stays 0. busy[0] is constant 0.
- Scoreboard set: Issue_Valid with Issue_Reg != 0 sets busy[Issue_Reg] on the edge.
- Scoreboard clear: on an edge where RegWrite=1, busy[Write_register] clears. This is the same edge on which Registers captures the data, so a register never reads non-busy before it holds the new value.
- Simultaneous set and clear of the same index: set wins, because a new producer has issued.
- Both requesters targeting the same register: arbitration applies as usual, and each write lands in grant order.

## Timing

- Reset (RESET_N low, asynchronous, effective immediately including mid-transfer):
  - RegWrite=0, Write_register=0, Write_Data=0.
  - busy=0, `prio`=B.
  - A_Ready and B_Ready still follow the combinational rules on Valid.
  - No write is issued until the first edge after reset release.
- Latency:
  - Handshake at edge N drives RegWrite high during cycle N+1.
  - Registers captures at edge N+1.
  - busy clears at edge N+1.
- Throughput: one write per cycle, sustained. Back-to-back grants produce RegWrite high on consecutive cycles.
- Starvation bound: under continuous contention a requester waits at most 1 cycle.
- Rs_Busy and Rt_Busy reflect the busy state after the last edge. They do not reflect the same-cycle Issue_Valid or same-cycle clear.

## Test plan

- Reset mid-write:
  - Stimulus: handshake A (Reg=5, Data=0x12345678), then assert RESET_N=0 halfway through the next cycle.
  - Response: RegWrite drops to 0 immediately; busy and Write_Data read 0; `prio`=B.
- Single requester:
  - Stimulus: A_Valid with Reg=8, Data=0xDEADBEEF for 1 cycle.
  - Response: A_Ready=1 that cycle; next cycle RegWrite=1, Write_register=8, Write_Data=0xDEADBEEF; the cycle after, RegWrite=0.
- Contention:
  - Stimulus: A and B valid for 4 cycles with distinct Regs (A: 9, B: 10).
  - Response: grant order B, A, B, A; RegWrite high on 4 consecutive cycles, alternating Write_register 10, 9, 10, 9.
- $zero:
  - Stimulus: B_Valid with Reg=0, Data=0xFFFFFFFF; also Issue_Valid with Issue_Reg=0.
  - Response: B_Ready=1; RegWrite stays 0; busy[0] stays 0.
- Scoreboard:
  - Stimulus: Issue_Reg=12, then A writes Reg=12 two cycles later.
  - Response: Rs_Busy=1 (Query_rs=12) from the issue edge until the edge on which RegWrite=1, then 0.
- Simultaneous set and clear:
  - Stimulus: reissue Reg=12 on the same edge RegWrite=1 for register 12.
  - Response: busy[12] remains 1.
